game_status_engine: RTL and testbench
=====================================

# game_status_engine

Parametrised successor to the fixed 8x8 win/loss checker in the minesweeper design. It sits between the board memory (map and click state) and the display/scoring logic. It sweeps the board sequentially, LANES cells per clock, tracks a game state machine and reports sticky `dead`/`won` flags plus the revealed-cell count. An optional elapsed-time counter can be compiled in.

## Interface
Parameters:
- `ROWS`, 8, board rows
- `COLS`, 8, board columns; CELLS = ROWS*COLS
- `CELL_W`, 4, bits per map cell
- `MINE_CODE`, 9, map value marking a mine (full CELL_W compare)
- `MINES`, 10, mine count; win target = CELLS-MINES
- `LANES`, 1, cells inspected per clock; must divide CELLS
- `TIME_W`, 10, elapsed counter width

Ports:
- `clk`  in  1  single clock; all logic is rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin/restart game (level sampled per clock)
- `map_flat`  in  CELLS*CELL_W  cell i at bits [i*CELL_W +: CELL_W]
- `clicked_flat`  in  CELLS  bit i = cell i revealed
- `sec_tick`  in  1  one-cycle 1 Hz strobe
- `playing`  out  1  state is SCAN
- `dead`  out  1  sticky mine-hit flag
- `won`  out  1  sticky win flag
- `num_revealed`  out  $clog2(CELLS+1)  safe revealed cells counted in the last completed sweep
- `sweep_done`  out  1  one-cycle pulse at the end of each sweep
- `elapsed`  out  TIME_W  seconds played

## Operation
- States: IDLE, SCAN, WON, DEAD.
- Reset (rst=0, asynchronous): state=IDLE, index=0, accumulators=0. All outputs 0.
- IDLE: `start`=1 -> SCAN with index=0 and accumulators cleared.
- SCAN, each cycle, for cells index..index+LANES-1:
  - hit |= clicked & (map==MINE_CODE)
  - count += clicked & (map!=MINE_CODE)
  - index += LANES
- Last group of a sweep (index+LANES==CELLS):
  - Update `num_revealed` with the final count, including the last group.
  - Pulse `sweep_done`.
  - If hit, go to DEAD. Else if count==CELLS-MINES, go to WON. Else stay in SCAN, with index=0 and accumulators cleared.
- Simultaneous hit and win count in one sweep: DEAD has priority.
- WON/DEAD: flags hold regardless of input changes. `start` -> SCAN, flags cleared, `num_revealed`=0.
- `start` during SCAN: the current sweep is abandoned. Index and accumulators clear, `num_revealed`=0, and scanning resumes from cell 0 the next cycle.
- Count arithmetic: unsigned, width $clog2(CELLS+1). It cannot overflow because count ≤ CELLS.
- Inputs are read directly each cycle with no snapshot. Changes mid-sweep affect only the cells not yet visited.

## Timing
- Sweep length: CELLS/LANES cycles. Default is 64.
- Flag latency: from a stable input change to `dead`/`won` is at most 2*CELLS/LANES cycles. Flags assert the cycle after the final group's edge.
- `sweep_done` asserts on the same edge that `num_revealed` updates.
- `playing` falls on the same edge that `dead`/`won` rise.
- Reset mid-sweep: all state clears asynchronously. After release, the block waits in IDLE for `start`.

## Configuration
- `GAME_STATUS_TIMER_EN` defined:
  - `elapsed` increments on `sec_tick` while in SCAN.
  - It saturates at 2^TIME_W-1 and freezes in WON/DEAD.
  - It clears on `start` and on reset.
- Not defined: `elapsed` is tied to 0, `sec_tick` is ignored, and no counter logic is synthesised.

## Structure
- Shared package `minesweeper_pkg`:
  - state enum (IDLE/SCAN/WON/DEAD)
  - MINE_CODE default
  - cell-index and count width helper functions
- Sub-module `game_scan_lane`: combinational over one LANES-wide group. It returns the group's hit bit and safe-click popcount. The top level owns the FSM, index, accumulators and timer.

## Test plan
1. Reset: rst=0 with arbitrary inputs -> `dead`=`won`=`playing`=0, `num_revealed`=0, `elapsed`=0. After release with `start`=0, the block stays in IDLE.
2. Mine hit: `start`; map_flat=9 (cell 0 mine); clicked_flat=all ones -> `dead`=1 and `won`=0 within 65 cycles. `dead` holds after clicked_flat=0.
3. Win: mines (code 9) in cells 0-9, clicked_flat bits 10-63 set -> `won`=1 and `num_revealed`=54 after one sweep. Repeat with LANES=8 and expect `won` within 8 cycles.
4. Near-win: same as scenario 3 but bit 63 clear -> `num_revealed`=53 and `playing` stays 1. Setting bit 63 mid-run -> `won` within 128 cycles.
5. Restart/reset mid-sweep:
   - `start` pulsed at cycle 30 of a sweep -> `num_revealed`=0, and `sweep_done` next fires 64 cycles later.
   - rst=0 at cycle 20 -> immediate IDLE.
6. Timer (with `GAME_STATUS_TIMER_EN`): 5 `sec_tick` pulses during SCAN -> `elapsed`=5. Ticks after `won` leave `elapsed`=5. With TIME_W=3 and 10 ticks -> `elapsed`=7.

Source files
------------

// File: rtl/minesweeper_pkg.sv
// Shared types and width helpers for the minesweeper game-status logic.
package minesweeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_WON  = 2'd2,
      ST_DEAD = 2'd3
   } game_state_t;

   localparam int MINE_CODE_DEF = 9;

   // Width of a cell index; never collapses below one bit.
   function automatic int idx_w(input int cells);
      if (cells > 1) begin
         return $clog2(cells);
      end else begin
         return 1;
      end
   endfunction

   // Width of a count that can reach n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/game_scan_lane.sv
// Combinational inspection of one LANES-wide group of board cells:
// reports whether a mine was clicked and how many safe cells were clicked.
module game_scan_lane
   import minesweeper_pkg::*;
#(
   parameter int LANES     = 1,
   parameter int CELL_W    = 4,
   parameter int MINE_CODE = MINE_CODE_DEF,
   localparam int LANE_W   = cnt_w(LANES)
) (
   input  logic [LANES*CELL_W-1:0] map_grp,
   input  logic [LANES-1:0]        clicked_grp,
   output logic                    hit,
   output logic [LANE_W-1:0]       safe_cnt
);

   logic              is_mine_s;
   logic              hit_s;
   logic [LANE_W-1:0] cnt_s;

   // Per-lane mine compare, OR-reduced hit and popcount of safe clicks.
   always_comb begin
      hit_s     = 1'b0;
      cnt_s     = '0;
      is_mine_s = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         is_mine_s = (map_grp[i*CELL_W +: CELL_W] == CELL_W'(MINE_CODE));
         hit_s     = hit_s | (clicked_grp[i] & is_mine_s);
         cnt_s     = cnt_s + LANE_W'(clicked_grp[i] & ~is_mine_s);
      end
   end

   assign hit      = hit_s;
   assign safe_cnt = cnt_s;

endmodule

// File: rtl/game_status_engine.sv
// Sequential board sweeper with IDLE/SCAN/WON/DEAD state machine and sticky flags.
// Optional elapsed-seconds counter compiled in with GAME_STATUS_TIMER_EN.
module game_status_engine
   import minesweeper_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int COLS      = 8,
   parameter int CELL_W    = 4,
   parameter int MINE_CODE = MINE_CODE_DEF,
   parameter int MINES     = 10,
   parameter int LANES     = 1,
   parameter int TIME_W    = 10,
   localparam int CELLS    = ROWS * COLS,
   localparam int CNT_W    = cnt_w(CELLS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CELLS*CELL_W-1:0] map_flat,
   input  logic [CELLS-1:0]        clicked_flat,
   input  logic                    sec_tick,
   output logic                    playing,
   output logic                    dead,
   output logic                    won,
   output logic [CNT_W-1:0]        num_revealed,
   output logic                    sweep_done,
   output logic [TIME_W-1:0]       elapsed
);

   localparam int IDX_W    = idx_w(CELLS);
   localparam int LANE_W   = cnt_w(LANES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - LANES);
   localparam logic [IDX_W-1:0] STEP_IDX = IDX_W'(LANES);
   localparam logic [CNT_W-1:0] WIN_CNT  = CNT_W'(CELLS - MINES);

   game_state_t       state_r;
   logic [IDX_W-1:0]  index_r;
   logic              hit_r;
   logic [CNT_W-1:0]  count_r;
   logic              playing_r;
   logic              dead_r;
   logic              won_r;
   logic [CNT_W-1:0]  num_revealed_r;
   logic              sweep_done_r;

   logic              lane_hit_s;
   logic [LANE_W-1:0] lane_cnt_s;
   logic              hit_next_s;
   logic [CNT_W-1:0]  count_next_s;

   game_scan_lane #(
      .LANES     (LANES),
      .CELL_W    (CELL_W),
      .MINE_CODE (MINE_CODE)
   ) u_lane (
      .map_grp     (map_flat[index_r*CELL_W +: LANES*CELL_W]),
      .clicked_grp (clicked_flat[index_r +: LANES]),
      .hit         (lane_hit_s),
      .safe_cnt    (lane_cnt_s)
   );

   assign hit_next_s   = hit_r | lane_hit_s;
   assign count_next_s = count_r + CNT_W'(lane_cnt_s);

   // Game FSM: sweep index, accumulators and all registered status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         index_r        <= '0;
         hit_r          <= 1'b0;
         count_r        <= '0;
         playing_r      <= 1'b0;
         dead_r         <= 1'b0;
         won_r          <= 1'b0;
         num_revealed_r <= '0;
         sweep_done_r   <= 1'b0;
      end else begin
         sweep_done_r <= 1'b0;
         case (state_r)
            ST_SCAN: begin
               if (start) begin
                  index_r        <= '0;
                  hit_r          <= 1'b0;
                  count_r        <= '0;
                  num_revealed_r <= '0;
               end else if (index_r == LAST_IDX) begin
                  // End of sweep: publish the count, then judge; a hit beats a win.
                  num_revealed_r <= count_next_s;
                  sweep_done_r   <= 1'b1;
                  index_r        <= '0;
                  hit_r          <= 1'b0;
                  count_r        <= '0;
                  if (hit_next_s) begin
                     state_r   <= ST_DEAD;
                     dead_r    <= 1'b1;
                     playing_r <= 1'b0;
                  end else if (count_next_s == WIN_CNT) begin
                     state_r   <= ST_WON;
                     won_r     <= 1'b1;
                     playing_r <= 1'b0;
                  end else begin
                     state_r <= ST_SCAN;
                  end
               end else begin
                  index_r <= index_r + STEP_IDX;
                  hit_r   <= hit_next_s;
                  count_r <= count_next_s;
               end
            end
            ST_IDLE, ST_WON, ST_DEAD: begin
               if (start) begin
                  state_r        <= ST_SCAN;
                  index_r        <= '0;
                  hit_r          <= 1'b0;
                  count_r        <= '0;
                  playing_r      <= 1'b1;
                  dead_r         <= 1'b0;
                  won_r          <= 1'b0;
                  num_revealed_r <= '0;
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               index_r   <= '0;
               hit_r     <= 1'b0;
               count_r   <= '0;
               playing_r <= 1'b0;
               dead_r    <= 1'b0;
               won_r     <= 1'b0;
            end
         endcase
      end
   end

`ifdef GAME_STATUS_TIMER_EN
   localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};
   logic [TIME_W-1:0] elapsed_r;

   // Saturating seconds counter that only runs while scanning.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elapsed_r <= '0;
      end else if (start) begin
         elapsed_r <= '0;
      end else if ((state_r == ST_SCAN) && sec_tick && (elapsed_r != TIME_MAX)) begin
         elapsed_r <= elapsed_r + TIME_W'(1);
      end else begin
         elapsed_r <= elapsed_r;
      end
   end

   assign elapsed = elapsed_r;
`else
   logic unused_tick_s;
   assign unused_tick_s = sec_tick;
   assign elapsed       = '0;
`endif

   assign playing      = playing_r;
   assign dead         = dead_r;
   assign won          = won_r;
   assign num_revealed = num_revealed_r;
   assign sweep_done   = sweep_done_r;

endmodule

// File: tb/tb_game_status_engine.sv
// Directed self-checking bench for game_status_engine (default, LANES=8 and TIME_W=3 builds).
module tb_game_status_engine;

   logic         clk;
   logic         rst;
   logic         start;
   logic [255:0] map_flat;
   logic [63:0]  clicked_flat;
   logic         sec_tick;

   logic       playing, dead, won, sweep_done;
   logic [6:0] num_revealed;
   logic [9:0] elapsed;
   logic       playing8, dead8, won8, sweep_done8;
   logic [6:0] num_revealed8;
   logic [9:0] elapsed8;
   logic       playing3, dead3, won3, sweep_done3;
   logic [6:0] num_revealed3;
   logic [2:0] elapsed3;

   int total = 0;
   int bad   = 0;

   game_status_engine dut (
      .clk(clk), .rst(rst), .start(start), .map_flat(map_flat),
      .clicked_flat(clicked_flat), .sec_tick(sec_tick), .playing(playing),
      .dead(dead), .won(won), .num_revealed(num_revealed),
      .sweep_done(sweep_done), .elapsed(elapsed)
   );

   game_status_engine #(.LANES(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .map_flat(map_flat),
      .clicked_flat(clicked_flat), .sec_tick(sec_tick), .playing(playing8),
      .dead(dead8), .won(won8), .num_revealed(num_revealed8),
      .sweep_done(sweep_done8), .elapsed(elapsed8)
   );

   game_status_engine #(.TIME_W(3)) dut3 (
      .clk(clk), .rst(rst), .start(start), .map_flat(map_flat),
      .clicked_flat(clicked_flat), .sec_tick(sec_tick), .playing(playing3),
      .dead(dead3), .won(won3), .num_revealed(num_revealed3),
      .sweep_done(sweep_done3), .elapsed(elapsed3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic set_map(input int nmines);
      for (int i = 0; i < 64; i++) map_flat[i*4 +: 4] = (i < nmines) ? 4'd9 : 4'd0;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b1; sec_tick = 1'b1;
      map_flat = {64{4'h9}}; clicked_flat = {64{1'b1}};
      step(3);
      total++;
      if ({playing, dead, won, sweep_done} !== 4'b0000 || num_revealed !== 7'd0 || elapsed !== 10'd0) begin
         bad++;
         $display("FAIL reset_outputs: got p=%b d=%b w=%b sd=%b nr=%0d el=%0d want all 0",
                  playing, dead, won, sweep_done, num_revealed, elapsed);
      end
      start = 1'b0; sec_tick = 1'b0;
      rst = 1'b1;
      step(5);
      total++;
      if (playing !== 1'b0 || dead !== 1'b0 || won !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle: got p=%b d=%b w=%b want 0 0 0", playing, dead, won);
      end
   endtask

   task automatic test_mine_hit();
      int seen;
      set_map(1);
      clicked_flat = {64{1'b1}};
      pulse_start();
      seen = 0;
      for (int c = 1; c <= 65; c++) begin
         step(1);
         if (dead === 1'b1) begin seen = c; break; end
      end
      total++;
      if (seen != 64) begin
         bad++;
         $display("FAIL mine_latency: dead seen at cycle %0d want 64", seen);
      end
      total++;
      if (won !== 1'b0 || playing !== 1'b0 || num_revealed !== 7'd63) begin
         bad++;
         $display("FAIL mine_status: got w=%b p=%b nr=%0d want 0 0 63", won, playing, num_revealed);
      end
      clicked_flat = '0;
      step(70);
      total++;
      if (dead !== 1'b1 || won !== 1'b0) begin
         bad++;
         $display("FAIL mine_sticky: got d=%b w=%b want 1 0", dead, won);
      end
   endtask

   task automatic test_priority();
      set_map(10);
      clicked_flat = {{54{1'b1}}, 9'd0, 1'b1};
      pulse_start();
      total++;
      if (dead !== 1'b0 || playing !== 1'b1) begin
         bad++;
         $display("FAIL prio_restart: got d=%b p=%b want 0 1", dead, playing);
      end
      step(64);
      total++;
      if (dead !== 1'b1 || won !== 1'b0 || num_revealed !== 7'd54) begin
         bad++;
         $display("FAIL prio_dead: got d=%b w=%b nr=%0d want 1 0 54", dead, won, num_revealed);
      end
   endtask

   task automatic test_win();
      set_map(10);
      clicked_flat = {{54{1'b1}}, 10'd0};
      pulse_start();
      total++;
      if (num_revealed !== 7'd0 || dead !== 1'b0) begin
         bad++;
         $display("FAIL win_restart: got nr=%0d d=%b want 0 0", num_revealed, dead);
      end
      for (int c = 1; c <= 64; c++) begin
         step(1);
         if (c == 7) begin
            total++;
            if (won8 !== 1'b0) begin
               bad++;
               $display("FAIL win8_early: got won8=%b at cycle 7 want 0", won8);
            end
         end
         if (c == 8) begin
            total++;
            if (won8 !== 1'b1 || num_revealed8 !== 7'd54 || playing8 !== 1'b0) begin
               bad++;
               $display("FAIL win8: got w=%b nr=%0d p=%b want 1 54 0", won8, num_revealed8, playing8);
            end
         end
         if (c == 63) begin
            total++;
            if (won !== 1'b0 || playing !== 1'b1) begin
               bad++;
               $display("FAIL win_early: got w=%b p=%b at cycle 63 want 0 1", won, playing);
            end
         end
      end
      total++;
      if (won !== 1'b1 || dead !== 1'b0 || playing !== 1'b0 || num_revealed !== 7'd54 || sweep_done !== 1'b1) begin
         bad++;
         $display("FAIL win: got w=%b d=%b p=%b nr=%0d sd=%b want 1 0 0 54 1",
                  won, dead, playing, num_revealed, sweep_done);
      end
   endtask

   task automatic test_near_win_restart();
      int seen;
      clicked_flat = {1'b0, {53{1'b1}}, 10'd0};
      pulse_start();
      step(64);
      total++;
      if (num_revealed !== 7'd53 || playing !== 1'b1 || sweep_done !== 1'b1 || won !== 1'b0) begin
         bad++;
         $display("FAIL near_win: got nr=%0d p=%b sd=%b w=%b want 53 1 1 0",
                  num_revealed, playing, sweep_done, won);
      end
      step(1);
      total++;
      if (sweep_done !== 1'b0) begin
         bad++;
         $display("FAIL sweep_pulse: got sd=%b want 0", sweep_done);
      end
      step(29);
      pulse_start();
      total++;
      if (num_revealed !== 7'd0 || playing !== 1'b1) begin
         bad++;
         $display("FAIL restart_mid: got nr=%0d p=%b want 0 1", num_revealed, playing);
      end
      seen = 0;
      for (int c = 1; c <= 64; c++) begin
         step(1);
         if (sweep_done === 1'b1) begin seen = c; break; end
      end
      total++;
      if (seen != 64 || num_revealed !== 7'd53) begin
         bad++;
         $display("FAIL restart_sweep: sweep_done at %0d nr=%0d want 64 53", seen, num_revealed);
      end
      clicked_flat[63] = 1'b1;
      seen = 0;
      for (int c = 1; c <= 128; c++) begin
         step(1);
         if (won === 1'b1) begin seen = c; break; end
      end
      total++;
      if (seen == 0 || num_revealed !== 7'd54) begin
         bad++;
         $display("FAIL late_win: won seen at %0d nr=%0d want within 128 and 54", seen, num_revealed);
      end
   endtask

   task automatic test_reset_mid();
      clicked_flat = '0;
      pulse_start();
      step(20);
      rst = 1'b0;
      #1;
      total++;
      if (playing !== 1'b0 || dead !== 1'b0 || won !== 1'b0 || num_revealed !== 7'd0) begin
         bad++;
         $display("FAIL reset_mid: got p=%b d=%b w=%b nr=%0d want 0 0 0 0", playing, dead, won, num_revealed);
      end
      step(2);
      rst = 1'b1;
      step(10);
      total++;
      if (playing !== 1'b0 || sweep_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle_after: got p=%b sd=%b want 0 0", playing, sweep_done);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         sec_tick = 1'b1;
         step(1);
         sec_tick = 1'b0;
         step(1);
      end
   endtask

   task automatic test_timer();
      int seen;
      logic [9:0] exp5, exp10;
      logic [2:0] exp_sat;
`ifdef GAME_STATUS_TIMER_EN
      exp5 = 10'd5; exp10 = 10'd10; exp_sat = 3'd7;
`else
      exp5 = 10'd0; exp10 = 10'd0; exp_sat = 3'd0;
`endif
      set_map(10);
      clicked_flat = '0;
      pulse_start();
      tick(5);
      total++;
      if (elapsed !== exp5) begin
         bad++;
         $display("FAIL timer_5: got %0d want %0d", elapsed, exp5);
      end
      clicked_flat = {{54{1'b1}}, 10'd0};
      seen = 0;
      for (int c = 1; c <= 128; c++) begin
         step(1);
         if (won === 1'b1) begin seen = c; break; end
      end
      tick(3);
      total++;
      if (seen == 0 || elapsed !== exp5) begin
         bad++;
         $display("FAIL timer_frozen: won at %0d elapsed=%0d want won and %0d", seen, elapsed, exp5);
      end
      clicked_flat = '0;
      pulse_start();
      total++;
      if (elapsed !== 10'd0 || elapsed3 !== 3'd0) begin
         bad++;
         $display("FAIL timer_clear: got %0d/%0d want 0/0", elapsed, elapsed3);
      end
      tick(10);
      total++;
      if (elapsed !== exp10 || elapsed3 !== exp_sat) begin
         bad++;
         $display("FAIL timer_sat: got %0d/%0d want %0d/%0d", elapsed, elapsed3, exp10, exp_sat);
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; sec_tick = 1'b0;
      map_flat = '0; clicked_flat = '0;
      test_reset();
      test_mine_hit();
      test_priority();
      test_win();
      test_near_win_restart();
      test_reset_mid();
      test_timer();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
